// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered multiplexer and its round-robin arbiter.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } mode_e;

    // Width of a channel index for an n-channel mux; never narrower than one bit.
    function automatic int unsigned selw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = selw(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    localparam int unsigned NU = N;

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    int unsigned    pos;
    int unsigned    idx;

    assign dbl = {req, req};

    // Scan the doubled request vector from ptr so the wrap needs no modulo on the request side.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos     = 0;
        idx     = 0;
        shifted = '0;
        for (int unsigned j = 0; j < NU; j++) begin
            pos     = int'(ptr) + j;
            shifted = dbl >> pos;
            if (en && !any && shifted[0]) begin
                any     = 1'b1;
                idx     = (pos >= NU) ? (pos - NU) : pos;
                gnt_idx = SELW'(idx);
                gnt     = {{(N-1){1'b0}}, 1'b1} << idx;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_rr.sv
// N-channel WIDTH-bit multiplexer with registered output, valid/ready handshake,
// and manual or round-robin channel selection.
module mux_n_1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = selw(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    localparam int unsigned NU = N;

    logic              load_en;
    logic              rr_mode;
    logic              rr_en;
    logic [SELW-1:0]   ptr;
    logic [N-1:0]      rr_gnt;
    logic [SELW-1:0]   rr_idx;
    logic              rr_any;
    logic [N-1:0]      man_gnt;
    logic              man_ok;
    logic [N-1:0]      grant;
    logic              gvalid;
    logic [SELW-1:0]   gidx;
    logic [N*WIDTH-1:0] data_sh;
    logic [WIDTH-1:0]  gdata;

    assign load_en = !out_valid || out_ready;
    assign rr_mode = (mode_e'(mode) == MODE_RR);
    assign rr_en   = load_en && !rst && rr_mode;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (rr_en),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // Manual select path: out-of-range sel never grants.
    always_comb begin
        man_gnt = '0;
        man_ok  = 1'b0;
        if (!rr_mode && load_en && !rst && (int'(sel) < NU)) begin
            if (in_valid[sel]) begin
                man_ok  = 1'b1;
                man_gnt = {{(N-1){1'b0}}, 1'b1} << sel;
            end
        end
    end

    // Merge the two grant sources and pick the granted word.
    always_comb begin
        grant    = rr_mode ? rr_gnt : man_gnt;
        gvalid   = rr_mode ? rr_any : man_ok;
        gidx     = rr_mode ? rr_idx : sel;
        data_sh  = in_data >> (int'(gidx) * WIDTH);
        gdata    = data_sh[WIDTH-1:0];
        in_ready = grant;
    end

    // Output register and round-robin pointer; both freeze while the output is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (gvalid) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_ch    <= gidx;
                if (rr_mode) begin
                    ptr <= (rr_idx == SELW'(N - 1)) ? '0 : rr_idx + SELW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Directed self-checking bench for mux_n_1_rr (N=4/WIDTH=8 and N=3/WIDTH=4 instances).
module tb_mux_n_1_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic [3:0]  in_valid = 4'hF;
    logic [3:0]  in_ready;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic        out_ready = 1'b1;

    logic        rst3 = 1'b1;
    logic [11:0] in_data3 = {4'h6, 4'h5, 4'h4};
    logic [2:0]  in_valid3 = 3'b111;
    logic [2:0]  in_ready3;
    logic        mode3 = 1'b1;
    logic [1:0]  sel3 = 2'd0;
    logic [3:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_ch3;
    logic        out_ready3 = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_n_1_rr #(.WIDTH(8), .N(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    mux_n_1_rr #(.WIDTH(4), .N(3)) dut3 (
        .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3), .out_data(out_data3), .out_valid(out_valid3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        repeat (2) begin
            step();
            checks++;
            if ({out_valid, out_ch, out_data, in_ready} !== 15'd0) begin
                $display("FAIL reset_state: got v=%b ch=%0d d=%h rdy=%b, expected all zero",
                         out_valid, out_ch, out_data, in_ready);
                errors++;
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            $display("FAIL reset_release_ready: got %b expected 0001", in_ready);
            errors++;
        end
        step();
        checks++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hA0}) begin
            $display("FAIL reset_first_load: got v=%b ch=%0d d=%h expected v=1 ch=0 d=a0",
                     out_valid, out_ch, out_data);
            errors++;
        end
    endtask

    task automatic test_manual();
        mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if (in_ready !== 4'(1 << s)) begin
                $display("FAIL manual_ready[%0d]: got %b expected %b", s, in_ready, 4'(1 << s));
                errors++;
            end
            step();
            checks++;
            if ({out_valid, out_ch, out_data} !== {1'b1, 2'(s), 8'(8'hA0 + s)}) begin
                $display("FAIL manual_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         s, out_valid, out_ch, out_data, s, 8'(8'hA0 + s));
                errors++;
            end
        end
        in_valid = 4'b1011; sel = 2'd2;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            $display("FAIL manual_invalid_ready: got %b expected 0000", in_ready);
            errors++;
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL manual_invalid_out: got out_valid=%b expected 0", out_valid);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        int exp2 [4] = '{0, 2, 0, 2};
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'(1 << (k % 4))) begin
                $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << (k % 4)));
                errors++;
            end
            step();
            checks++;
            if ({out_valid, out_ch, out_data} !== {1'b1, 2'(k % 4), 8'(8'hA0 + k % 4)}) begin
                $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h expected ch=%0d",
                         k, out_valid, out_ch, out_data, k % 4);
                errors++;
            end
        end
        in_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({out_valid, out_ch} !== {1'b1, 2'(exp2[k])}) begin
                $display("FAIL rr_sparse[%0d]: got v=%b ch=%0d expected v=1 ch=%0d",
                         k, out_valid, out_ch, exp2[k]);
                errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        step();
        rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            $display("FAIL bp_first_ready: got %b expected 0001", in_ready);
            errors++;
        end
        step();
        repeat (3) begin
            checks++;
            if (in_ready !== 4'b0000) begin
                $display("FAIL bp_hold_ready: got %b expected 0000", in_ready);
                errors++;
            end
            step();
            checks++;
            if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 8'hA0}) begin
                $display("FAIL bp_hold_out: got v=%b ch=%0d d=%h expected v=1 ch=0 d=a0",
                         out_valid, out_ch, out_data);
                errors++;
            end
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'(1 << k)) begin
                $display("FAIL bp_release_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << k));
                errors++;
            end
            step();
            checks++;
            if ({out_valid, out_ch, out_data} !== {1'b1, 2'(k), 8'(8'hA0 + k)}) begin
                $display("FAIL bp_release_out[%0d]: got v=%b ch=%0d d=%h expected ch=%0d",
                         k, out_valid, out_ch, out_data, k);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        out_ready = 1'b0; in_valid = 4'b1010;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            $display("FAIL hold_ready: got %b expected 0000", in_ready);
            errors++;
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            $display("FAIL rst_hold_ready: got %b expected 0000", in_ready);
            errors++;
        end
        step();
        checks++;
        if ({out_valid, out_ch, out_data} !== 11'd0) begin
            $display("FAIL rst_hold_out: got v=%b ch=%0d d=%h expected all zero",
                     out_valid, out_ch, out_data);
            errors++;
        end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            $display("FAIL rst_ptr_ready: got %b expected 0010", in_ready);
            errors++;
        end
        step();
        checks++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'hA1}) begin
            $display("FAIL rst_ptr_out: got v=%b ch=%0d d=%h expected v=1 ch=1 d=a1",
                     out_valid, out_ch, out_data);
            errors++;
        end
    endtask

    task automatic test_wrap_n3();
        rst3 = 1'b1; mode3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1;
        step();
        rst3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (in_ready3 !== 3'(1 << (k % 3))) begin
                $display("FAIL wrap_ready[%0d]: got %b expected %b", k, in_ready3, 3'(1 << (k % 3)));
                errors++;
            end
            step();
            checks++;
            if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'(k % 3), 4'(4 + k % 3)}) begin
                $display("FAIL wrap_out[%0d]: got v=%b ch=%0d d=%h expected ch=%0d",
                         k, out_valid3, out_ch3, out_data3, k % 3);
                errors++;
            end
        end
        mode3 = 1'b0; sel3 = 2'd3;
        #1;
        checks++;
        if (in_ready3 !== 3'b000) begin
            $display("FAIL sel_oor_ready: got %b expected 000", in_ready3);
            errors++;
        end
        step();
        checks++;
        if (out_valid3 !== 1'b0) begin
            $display("FAIL sel_oor_out: got out_valid=%b expected 0", out_valid3);
            errors++;
        end
        sel3 = 2'd1;
        #1;
        checks++;
        if (in_ready3 !== 3'b010) begin
            $display("FAIL sel_n3_ready: got %b expected 010", in_ready3);
            errors++;
        end
        step();
        checks++;
        if ({out_valid3, out_ch3, out_data3} !== {1'b1, 2'd1, 4'h5}) begin
            $display("FAIL sel_n3_out: got v=%b ch=%0d d=%h expected v=1 ch=1 d=5",
                     out_valid3, out_ch3, out_data3);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_round_robin();
        test_backpressure();
        test_reset_mid_hold();
        test_wrap_n3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_1_rr.md
# mux_n_1_rr

Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and per-channel valid/ready handshake. It extends the combinational 2:1 mux: any channel count, any data width, and a selectable arbitration mode (manual select or round-robin). It sits between multiple producer streams and a single consumer and grants at most one channel per cycle. The output is held stable under backpressure.

## Interface
- WIDTH, 8: data width per channel, ≥1
- N, 4: channel count, ≥2
- SELW, $clog2(N): select and channel-index width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  N*WIDTH  packed channels; channel i is bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel accept; at most one bit high (combinational)
- mode  in  1  0 = manual (use sel), 1 = round-robin
- sel  in  SELW  channel index in manual mode
- out_data  out  WIDTH  registered data
- out_valid  out  1  registered valid
- out_ch  out  SELW  index of the channel held in out_data
- out_ready  in  1  consumer accept

## Operation
- One output register (out_data, out_valid, out_ch).
- load_en = !out_valid | out_ready.
- A transfer on channel i happens when in_valid[i] & in_ready[i]. The output transfers when out_valid & out_ready.

Grant, combinational, computed every cycle:
- Manual: grant channel sel if sel < N and in_valid[sel]. Otherwise no grant; sel ≥ N never grants.
- Round-robin: pointer ptr (SELW bits). Grant the first i with in_valid[i], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 with modulo-N wrap (N need not be a power of two). No valid channel means no grant.

Handshake and update rules:
- in_ready = one-hot(grant) when load_en, else all zero. in_ready may depend on in_valid, mode and sel; it never depends on out_valid through a combinational loop.
- On load: out_data ← granted channel data, out_ch ← granted index, out_valid ← 1.
- load_en with no grant: out_valid ← 0. out_data and out_ch hold their values.
- Holding (out_valid & !out_ready): all outputs stable, no in_ready asserted.
- ptr updates only on a round-robin grant: ptr ← (granted + 1) mod N. Manual grants and mode switches leave ptr unchanged.
- Mode or sel changes take effect at the next grant decision. A held output is never altered.

## Timing
- Latency: input accepted in cycle t appears on out_data/out_valid at t+1.
- Throughput: one word per cycle while out_ready=1.
- Reset (synchronous, rst=1 at clock edge) sets out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is all zero while rst=1.
- Reset mid-operation: a held word is dropped, with no transfer to the consumer.
- Simultaneous output consume and new load in the same cycle: the new word replaces the old one with no bubble.
- Producers must keep in_valid and data stable until accepted. The block does not check this.

## Structure
- Shared package/header mux_pkg: MODE_MANUAL=1'b0, MODE_RR=1'b1, and the clog2-based SELW helper.
- One sub-module, rr_arbiter:
  - parameter N
  - inputs req[N], ptr, en
  - outputs gnt one-hot[N], gnt_idx, any
  - purely combinational, with wrap via a doubled request vector
- Top level holds ptr, the output register, the manual select path and the in_ready fan-out.

## Test plan
- Reset: assert rst for 2 cycles with all in_valid=1. Required: out_valid=0, out_data=0, out_ch=0, in_ready=0 throughout; first load occurs on the cycle after rst falls.
- Manual sweep (WIDTH=8, N=4): in_data channel i = 8'hA0+i, all valid, out_ready=1, sel stepped 0..3 then 4'd? out of range not possible at N=4. Required: out_data = A0, A1, A2, A3 one cycle after each sel, with out_ch matching. Separately, with in_valid=4'b1011 and sel=2: out_valid=0 and in_ready=0.
- Round-robin fairness: in_valid=4'b1111, out_ready=1, mode=1. Required: out_ch sequence 0,1,2,3,0,… with in_ready cycling one-hot. With in_valid=4'b0101 the sequence is 0,2,0,2.
- Backpressure: mode=1, out_ready=0 for 3 cycles after the first load. Required: out_data, out_ch and out_valid stay stable, in_ready=0, ptr frozen. On release the next channel is granted with no word lost or duplicated.
- Non-power-of-two wrap (N=3, WIDTH=4): all valid, mode=1. Required: out_ch 0,1,2,0 and never 3.
- Reset mid-hold: with out_valid=1 and out_ready=0, assert rst for 1 cycle. Required: out_valid=0 next cycle and ptr=0, so the next round-robin grant is the lowest valid channel.
